fft_agu_seq: RTL and testbench

Sequencing address generation unit for the in-place radix-2 FFT core. It steps autonomously through every level and butterfly index of an N = 2^M point transform and issues registered read addresses, twiddle addresses and delayed write-back addresses. It inserts pipeline-drain gaps between levels and honours a global stall. It sits between the FFT controller (start/done handshake) and the dual-port sample RAM, twiddle ROM and butterfly datapath.

---
 rtl/fft_agu_seq.sv | 185 ++++++++++++++++++
 tb/tb_fft_agu_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_agu_seq.sv
// ============================================================================
// Module : fft_agu_seq
// Brief  : Sequencing address generator for an in-place radix-2 FFT: issues
//          rotated butterfly read addresses, twiddle addresses and delayed
//          write-back addresses, with inter-level drain gaps and global stall.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_agu_seq #(
  parameter int M    = 9,
  parameter int PIPE = 4,
  localparam int LW  = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          inv,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] level_out,
  output logic          rd_valid,
  output logic [M-1:0]  rd_adr_a,
  output logic [M-1:0]  rd_adr_b,
  output logic [M-2:0]  twiddle_adr,
  output logic          twiddle_conj,
  output logic          wr_en,
  output logic [M-1:0]  wr_adr_a,
  output logic [M-1:0]  wr_adr_b
);

  localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;
  localparam int XW = 2 * M + 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_FIN   = 2'd3;

  localparam logic [DW-1:0] c_DRAIN_LAST = DW'(PIPE - 1);
  localparam logic [LW-1:0] c_LEVEL_LAST = LW'(M - 1);
  localparam logic [LW:0]   c_M          = (LW + 1)'(M);

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [M-2:0]  index_q, index_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          inv_q, inv_d;

  logic          busy_q;
  logic          done_q;
  logic          rdv_q;
  logic [M-1:0]  rda_q;
  logic [M-1:0]  rdb_q;
  logic [M-2:0]  tw_q;
  logic [LW-1:0] lvl_q;
  logic [XW-1:0] dl_q [PIPE];

  logic          w_frozen;
  logic [M-1:0]  w_adr_a;
  logic [M-1:0]  w_adr_b;
  logic [LW:0]   w_rsh;
  logic [M-1:0]  w_rot_a;
  logic [M-1:0]  w_rot_b;
  logic [LW-1:0] w_tw_sh;
  logic [M-2:0]  w_tw_mask;
  logic [M-2:0]  w_tw;

  // IDLE never freezes so that a start presented together with stall is taken.
  assign w_frozen = stall & (state_q != c_IDLE);

  // Level L butterfly addresses are the level-0 pair rotated left by L bits.
  assign w_adr_a = {index_q, 1'b0};
  assign w_adr_b = {index_q, 1'b1};
  assign w_rsh   = c_M - {1'b0, level_q};
  assign w_rot_a = (w_adr_a << level_q) | (w_adr_a >> w_rsh);
  assign w_rot_b = (w_adr_b << level_q) | (w_adr_b >> w_rsh);

  assign w_tw_sh   = c_LEVEL_LAST - level_q;
  assign w_tw_mask = {(M - 1){1'b1}} << w_tw_sh;
  assign w_tw      = index_q & w_tw_mask;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    index_d = index_q;
    dcnt_d  = dcnt_q;
    inv_d   = inv_q;
    case (state_q)
      c_IDLE: begin
        if (start) begin
          state_d = c_RUN;
          level_d = '0;
          index_d = '0;
          inv_d   = inv;
        end
      end
      c_RUN: begin
        index_d = index_q + (M - 1)'(1);
        if (&index_q) begin
          state_d = c_DRAIN;
          dcnt_d  = '0;
        end
      end
      c_DRAIN: begin
        if (dcnt_q == c_DRAIN_LAST) begin
          if (level_q == c_LEVEL_LAST) begin
            state_d = c_FIN;
          end else begin
            state_d = c_RUN;
            level_d = level_q + LW'(1);
            index_d = '0;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      c_FIN: begin
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_IDLE;
      level_q <= '0;
      index_q <= '0;
      dcnt_q  <= '0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdv_q   <= 1'b0;
      rda_q   <= '0;
      rdb_q   <= '0;
      tw_q    <= '0;
      lvl_q   <= '0;
      for (int i = 0; i < PIPE; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      // busy/done track the FSM every edge so done stays a single-cycle pulse.
      done_q <= (state_q == c_FIN) && !stall;
      busy_q <= (state_q == c_RUN) || (state_q == c_DRAIN) ||
                ((state_q == c_FIN) && stall);
      if (!w_frozen) begin
        state_q <= state_d;
        level_q <= level_d;
        index_q <= index_d;
        dcnt_q  <= dcnt_d;
        inv_q   <= inv_d;
        rdv_q   <= (state_q == c_RUN);
        if (state_q == c_RUN) begin
          rda_q <= w_rot_a;
          rdb_q <= w_rot_b;
          tw_q  <= w_tw;
          lvl_q <= level_q;
        end
        dl_q[0] <= {rdv_q, rda_q, rdb_q};
        for (int i = 1; i < PIPE; i++) begin
          dl_q[i] <= dl_q[i-1];
        end
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign level_out    = lvl_q;
  assign rd_valid     = rdv_q & ~w_frozen;
  assign rd_adr_a     = rda_q;
  assign rd_adr_b     = rdb_q;
  assign twiddle_adr  = tw_q;
  assign twiddle_conj = inv_q;
  assign wr_en        = dl_q[PIPE-1][XW-1] & ~w_frozen;
  assign wr_adr_a     = dl_q[PIPE-1][2*M-1:M];
  assign wr_adr_b     = dl_q[PIPE-1][M-1:0];

endmodule

`default_nettype wire

// File: tb/tb_fft_agu_seq.sv
// ============================================================================
// Module : tb_fft_agu_seq
// Brief  : Self-checking bench for fft_agu_seq against a slot-based timing and
//          address model, using M=4/PIPE=2, M=5/PIPE=4 and M=10/PIPE=3.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_agu_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic inv = 1'b0;
  logic stall = 1'b0;

  always #5 clk = ~clk;

  logic        a_busy, a_done, a_rdv, a_conj, a_wen;
  logic [1:0]  a_lvl;
  logic [3:0]  a_ra, a_rb, a_wa, a_wb;
  logic [2:0]  a_tw;

  logic        b_busy, b_done, b_rdv, b_conj, b_wen;
  logic [2:0]  b_lvl;
  logic [4:0]  b_ra, b_rb, b_wa, b_wb;
  logic [3:0]  b_tw;

  logic        c_busy, c_done, c_rdv, c_conj, c_wen;
  logic [3:0]  c_lvl;
  logic [9:0]  c_ra, c_rb, c_wa, c_wb;
  logic [8:0]  c_tw;

  fft_agu_seq #(.M(4), .PIPE(2)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .inv(inv), .stall(stall),
    .busy(a_busy), .done(a_done), .level_out(a_lvl), .rd_valid(a_rdv),
    .rd_adr_a(a_ra), .rd_adr_b(a_rb), .twiddle_adr(a_tw), .twiddle_conj(a_conj),
    .wr_en(a_wen), .wr_adr_a(a_wa), .wr_adr_b(a_wb)
  );

  fft_agu_seq #(.M(5), .PIPE(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .inv(inv), .stall(stall),
    .busy(b_busy), .done(b_done), .level_out(b_lvl), .rd_valid(b_rdv),
    .rd_adr_a(b_ra), .rd_adr_b(b_rb), .twiddle_adr(b_tw), .twiddle_conj(b_conj),
    .wr_en(b_wen), .wr_adr_a(b_wa), .wr_adr_b(b_wb)
  );

  fft_agu_seq #(.M(10), .PIPE(3)) u_dut_c (
    .clk(clk), .reset(reset), .start(start), .inv(inv), .stall(stall),
    .busy(c_busy), .done(c_done), .level_out(c_lvl), .rd_valid(c_rdv),
    .rd_adr_a(c_ra), .rd_adr_b(c_rb), .twiddle_adr(c_tw), .twiddle_conj(c_conj),
    .wr_en(c_wen), .wr_adr_a(c_wa), .wr_adr_b(c_wb)
  );

  // Monitored view of whichever instance the current run targets.
  int          sel = 0;
  logic        mv_busy, mv_done, mv_rdv, mv_conj, mv_wen;
  logic [15:0] mv_lvl, mv_a, mv_b, mv_tw, mv_wa, mv_wb;

  always_comb begin
    mv_busy = 1'b0; mv_done = 1'b0; mv_rdv = 1'b0; mv_conj = 1'b0; mv_wen = 1'b0;
    mv_lvl = '0; mv_a = '0; mv_b = '0; mv_tw = '0; mv_wa = '0; mv_wb = '0;
    case (sel)
      0: begin
        mv_busy = a_busy; mv_done = a_done; mv_rdv = a_rdv; mv_conj = a_conj; mv_wen = a_wen;
        mv_lvl = 16'(a_lvl); mv_a = 16'(a_ra); mv_b = 16'(a_rb); mv_tw = 16'(a_tw);
        mv_wa = 16'(a_wa); mv_wb = 16'(a_wb);
      end
      1: begin
        mv_busy = b_busy; mv_done = b_done; mv_rdv = b_rdv; mv_conj = b_conj; mv_wen = b_wen;
        mv_lvl = 16'(b_lvl); mv_a = 16'(b_ra); mv_b = 16'(b_rb); mv_tw = 16'(b_tw);
        mv_wa = 16'(b_wa); mv_wb = 16'(b_wb);
      end
      default: begin
        mv_busy = c_busy; mv_done = c_done; mv_rdv = c_rdv; mv_conj = c_conj; mv_wen = c_wen;
        mv_lvl = 16'(c_lvl); mv_a = 16'(c_ra); mv_b = 16'(c_rb); mv_tw = 16'(c_tw);
        mv_wa = 16'(c_wa); mv_wb = 16'(c_wb);
      end
    endcase
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic: left rotation of an m-bit value, masked twiddle index.
  function automatic int rotl(input int x, input int l, input int m);
    return ((x << l) | (x >> (m - l))) % (1 << m);
  endfunction

  function automatic int twid(input int idx, input int l, input int m);
    int sh;
    sh = m - 1 - l;
    return (idx >> sh) << sh;
  endfunction

  // Unstalled-timeline slot u -> (level, index) of the read scheduled there.
  function automatic bit slot(input int u, input int m, input int p, output int lv, output int ix);
    int per;
    per = (1 << (m - 1)) + p;
    lv = 0;
    ix = 0;
    if (u < 1) return 1'b0;
    lv = (u - 1) / per;
    ix = (u - 1) % per;
    return (lv < m) && (ix < (1 << (m - 1)));
  endfunction

  function automatic bit all_zero();
    return !(mv_busy | mv_done | mv_rdv | mv_conj | mv_wen) &&
           (mv_lvl == 0) && (mv_a == 0) && (mv_b == 0) && (mv_tw == 0) &&
           (mv_wa == 0) && (mv_wb == 0);
  endfunction

  int rot_lv [4] = '{1, 2, 3, 0};
  int rot_ix [4] = '{3, 3, 5, 5};
  int rot_a  [4] = '{12, 9, 5, 10};
  int rot_b  [4] = '{14, 13, 13, 11};
  int rot_t  [4] = '{0, 2, 5, 0};

  task automatic run_transform(input int s, input int stall_pct, input bit inv_v,
                               input bit poke, input bit do_reset);
    int  m, p, n2, per, u, nst, nrd, nwr, maxtw, c_done, budget;
    int  lr, ir, lw, iw;
    bit  er, ew, fin;
    m = (s == 0) ? 4 : (s == 1) ? 5 : 10;
    p = (s == 0) ? 2 : (s == 1) ? 4 : 3;
    n2 = 1 << (m - 1);
    per = n2 + p;
    budget = 3 * m * per + 100;
    sel = s;
    if (do_reset) begin
      @(negedge clk);
      reset = 1'b1; start = 1'b0; stall = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1 check_eq("reset_outputs_zero", 64'(!all_zero()), 64'd0);
    end
    @(negedge clk);
    start = 1'b1;
    inv = inv_v;
    stall = (stall_pct > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    u = 0; nst = 0; nrd = 0; nwr = 0; maxtw = 0; c_done = -1; fin = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 99) < stall_pct);
      if (poke && (nrd < m * n2)) begin
        start = ($urandom_range(0, 3) == 0);
        inv = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      #1;
      er = slot(u, m, p, lr, ir) && !stall;
      ew = slot(u - p, m, p, lw, iw) && !stall;
      check_eq("rd_valid", 64'(mv_rdv), 64'(er));
      if (er) begin
        check_eq("rd_adr_a", 64'(mv_a), 64'(rotl(2 * ir, lr, m)));
        check_eq("rd_adr_b", 64'(mv_b), 64'(rotl(2 * ir + 1, lr, m)));
        check_eq("twiddle_adr", 64'(mv_tw), 64'(twid(ir, lr, m)));
        check_eq("level_out", 64'(mv_lvl), 64'(lr));
        check_eq("twiddle_conj", 64'(mv_conj), 64'(inv_v));
        if (int'(mv_tw) > maxtw) maxtw = int'(mv_tw);
        if (s == 0) begin
          for (int k = 0; k < 4; k++) begin
            if (lr == rot_lv[k] && ir == rot_ix[k]) begin
              check_eq("rot_vec_a", 64'(mv_a), 64'(rot_a[k]));
              check_eq("rot_vec_b", 64'(mv_b), 64'(rot_b[k]));
              check_eq("rot_vec_tw", 64'(mv_tw), 64'(rot_t[k]));
            end
          end
        end
      end
      check_eq("wr_en", 64'(mv_wen), 64'(ew));
      if (ew) begin
        check_eq("wr_adr_a", 64'(mv_wa), 64'(rotl(2 * iw, lw, m)));
        check_eq("wr_adr_b", 64'(mv_wb), 64'(rotl(2 * iw + 1, lw, m)));
      end
      if (mv_rdv) nrd++;
      if (mv_wen) nwr++;
      check_eq("busy", 64'(mv_busy), 64'((c >= 1) && (u <= m * per)));
      check_eq("done", 64'(mv_done), 64'(u == m * per + 1));
      if (u == m * per + 1) begin
        c_done = c;
        fin = 1'b1;
        break;
      end
      if (stall) nst++;
      else u++;
    end
    start = 1'b0;
    stall = 1'b0;
    if (!fin) check_eq("done_timeout", 64'd0, 64'd1);
    check_eq("rd_count", 64'(nrd), 64'(m * n2));
    check_eq("wr_count", 64'(nwr), 64'(m * n2));
    check_eq("done_cycle", 64'(c_done), 64'(m * per + 1 + nst));
    if (s == 2) check_eq("twiddle_max", 64'(maxtw), 64'd511);
  endtask

  task automatic reset_mid_level2();
    bit hit;
    hit = 1'b0;
    sel = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    inv = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (mv_rdv && mv_lvl == 2) begin
        hit = 1'b1;
        break;
      end
    end
    check_eq("reach_level2", 64'(hit), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    #1 check_eq("midrun_reset_zero", 64'(!all_zero()), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    #1 check_eq("idle_after_reset", 64'(mv_busy | mv_rdv | mv_wen), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    run_transform(0, 0, 1'b0, 1'b0, 1'b1);
    run_transform(0, 0, 1'b1, 1'b1, 1'b1);
    run_transform(1, 0, 1'b0, 1'b0, 1'b1);
    run_transform(1, 30, 1'b1, 1'b1, 1'b1);
    run_transform(1, 15, 1'b0, 1'b0, 1'b1);
    reset_mid_level2();
    run_transform(0, 0, 1'b0, 1'b0, 1'b0);
    run_transform(2, 10, 1'b1, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
